lfsr_rng_pool: RTL and testbench
================================

Name: lfsr_rng_pool

Overview:
- Parametrised Galois-LFSR pseudo-random source for the console's RNG peripheral.
- Generalises the fixed 16-bit generator in four ways: configurable width, tap mask and user-input count; a zero-lockup guard; a read handshake; and a decorrelation gap of GAP LFSR steps between consecutive draws.
- Entropy is mixed in from a free-running cycle counter on calibration completion and on every user-input change.
- Sits between the memory-mapped I/O decoder (reads the number) and the input buffer (supplies buf_inputs).

Parameters:
- WIDTH, 16, LFSR state width in bits (>=4).
- TAPS, 16'hB400, Galois feedback mask XORed into the shifted state when the shifted-out bit is 1.
- OUT_BITS, 16, delivered word width (<=WIDTH); rnd = state[OUT_BITS-1:0] at capture.
- NUM_INPUTS, 8, width of buf_inputs.
- GAP, 4, LFSR steps between an accepted read and the next valid word (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- calib_done  in  1  memory calibration done; its rising edge is the primary seed event.
- buf_inputs  in  NUM_INPUTS  debounced user inputs; any change is a reseed event.
- rd_en  in  1  consumer takes rnd this cycle; honoured only when rnd_valid=1.
- rnd  out  OUT_BITS  current random word; held stable while rnd_valid=1.
- rnd_valid  out  1  rnd holds a fresh, unread word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=1, counter<=0, prev_calib<=0, prev_inputs<=buf_inputs (no spurious change event after reset).
  - rnd<=0, rnd_valid<=0, FSM<=WAIT_SEED, gap_cnt<=0.
  - Reset mid-operation aborts any FILL; the next word requires a new calib_done rising edge.
- Every cycle: counter<=counter+1 (wraps at 2^WIDTH); prev_calib<=calib_done; prev_inputs<=buf_inputs.
- Seed event = (calib_done & ~prev_calib) | (buf_inputs != prev_inputs).
  - On a seed event: mixed = state ^ counter; state<=(mixed==0) ? 1 : mixed; counter<=0 (overrides increment).
  - Otherwise state steps: state <= (state>>1) ^ (state[0] ? TAPS : 0).
  - State is never 0 after reset.
- FSM:
  - WAIT_SEED: rnd_valid=0; rd_en ignored. On a calib rising edge -> FILL, gap_cnt<=GAP-1. Input-change events mix state but do not leave WAIT_SEED.
  - FILL: rnd_valid=0. If gap_cnt==0: rnd<=state[OUT_BITS-1:0] (the pre-update register value), rnd_valid<=1, -> READY. Else gap_cnt<=gap_cnt-1. FILL lasts exactly GAP cycles. Seed events during FILL do not restart the gap.
  - READY: rnd_valid=1, rnd frozen. rd_en=1 -> FILL, gap_cnt<=GAP-1, rnd_valid<=0 next cycle. Seed events and calib edges in READY do not invalidate or alter rnd.
- Latency:
  - Read accepted at edge t: rnd_valid=0 from t+1; rnd_valid=1 again after edge t+GAP.
  - Peak draw rate is one word per GAP+1 cycles.
- Boundary cases:
  - calib_done falling edge has no effect.
  - Simultaneous calib edge and input change count as one seed event (single XOR).
  - rd_en while rnd_valid=0 is dropped, with no queuing.
  - Counter wrap is silent.

Test Plan:
- Reset, WIDTH=16, TAPS=16'hB400, inputs constant, calib_done low -> state steps 0x0001, 0xB400, 0x5A00, 0x2D00; rnd=0, rnd_valid=0 throughout.
- Reset, GAP=4, calib_done rises while counter=5 and state=S -> state = S^5 next edge; counter=0; rnd_valid high 4 cycles later; rnd = the state value at that capture edge.
- Zero guard, WIDTH=4, TAPS=4'hC: after reset state/counter run 1/0, C/1, 6/2, 3/3; toggle buf_inputs so the event is sampled at state=3, counter=3 -> state=1 (not 0), counter=0.
- Handshake, GAP=4, READY: hold rd_en=1 for 10 cycles -> exactly 2 words accepted, 5 cycles apart; each rnd stable while valid; consecutive words differ.
- Input toggles during READY -> rnd and rnd_valid unchanged; state ^= counter on each toggle. rd_en pulses in WAIT_SEED -> no effect.
- Assert rst during FILL -> rnd=0, rnd_valid=0, state=1. A new calib rising edge is required before rnd_valid returns.

Source files
------------

// File: rtl/lfsr_rng_pool.sv
// Galois-LFSR random-number source with entropy reseeding, a zero-lockup guard,
// a read handshake and a GAP-step decorrelation interval between delivered words.
module lfsr_rng_pool #(
  parameter int                 WIDTH      = 16,
  parameter logic [WIDTH-1:0]   TAPS       = 16'hB400,
  parameter int                 OUT_BITS   = 16,
  parameter int                 NUM_INPUTS = 8,
  parameter int                 GAP        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calib_done,
  input  logic [NUM_INPUTS-1:0] buf_inputs,
  input  logic                  rd_en,
  output logic [OUT_BITS-1:0]   rnd,
  output logic                  rnd_valid
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    WAIT_SEED,
    FILL,
    READY
  } fsm_e;

  fsm_e                  fsm;
  logic [WIDTH-1:0]      state;
  logic [WIDTH-1:0]      counter;
  logic                  prev_calib;
  logic [NUM_INPUTS-1:0] prev_inputs;
  logic [GW-1:0]         gap_cnt;

  logic                  calib_rise;
  logic                  seed_evt;
  logic [WIDTH-1:0]      mixed;
  logic [WIDTH-1:0]      stepped;

  assign calib_rise = calib_done & ~prev_calib;
  assign seed_evt   = calib_rise | (buf_inputs != prev_inputs);
  assign mixed      = state ^ counter;
  assign stepped    = (state >> 1) ^ (state[0] ? TAPS : '0);

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; FILL's capture of state relies on seeing the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WIDTH'(1);
      counter     <= '0;
      prev_calib  <= 1'b0;
      // Track the live inputs so leaving reset is not mistaken for a change.
      prev_inputs <= buf_inputs;
      rnd         <= '0;
      rnd_valid   <= 1'b0;
      fsm         <= WAIT_SEED;
      gap_cnt     <= '0;
    end else begin
      prev_calib  <= calib_done;
      prev_inputs <= buf_inputs;

      // A zero mix would lock the LFSR forever, so it is forced to 1.
      if (seed_evt) begin
        state   <= (mixed == '0) ? WIDTH'(1) : mixed;
        counter <= '0;
      end else begin
        state   <= stepped;
        counter <= counter + 1'b1;
      end

      case (fsm)
        WAIT_SEED: begin
          if (calib_rise) begin
            fsm     <= FILL;
            gap_cnt <= GW'(GAP - 1);
          end
        end
        FILL: begin
          if (gap_cnt == '0) begin
            rnd       <= state[OUT_BITS-1:0];
            rnd_valid <= 1'b1;
            fsm       <= READY;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        READY: begin
          if (rd_en) begin
            fsm       <= FILL;
            gap_cnt   <= GW'(GAP - 1);
            rnd_valid <= 1'b0;
          end
        end
        default: fsm <= WAIT_SEED;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_pool.sv
// Self-checking bench for lfsr_rng_pool: directed vector table, hand-written
// corner sequences and a randomized run against a cycle-level behavioural model.
module tb_lfsr_rng_pool;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        calib_done;
  logic [7:0]  buf_inputs;
  logic        rd_en;
  logic [15:0] rnd;
  logic        rnd_valid;

  logic        calib4;
  logic [1:0]  in4;
  logic        rd4;
  logic [3:0]  rnd4;
  logic        valid4;

  always #5 clk = ~clk;

  lfsr_rng_pool dut (
    .clk       (clk),
    .rst       (rst),
    .calib_done(calib_done),
    .buf_inputs(buf_inputs),
    .rd_en     (rd_en),
    .rnd       (rnd),
    .rnd_valid (rnd_valid)
  );

  lfsr_rng_pool #(
    .WIDTH(4), .TAPS(4'hC), .OUT_BITS(4), .NUM_INPUTS(2), .GAP(2)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .calib_done(calib4),
    .buf_inputs(in4),
    .rd_en     (rd4),
    .rnd       (rnd4),
    .rnd_valid (valid4)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: state, counter, edge trackers, and a mode/age pair
  // that counts cycles spent filling instead of a down-counter.
  logic [15:0] m_state, m_cnt, m_rnd;
  logic        m_prev_calib, m_valid;
  logic [7:0]  m_prev_in;
  int          m_mode;   // 0 waiting for seed, 1 filling, 2 word ready
  int          m_age;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_edge();
    bit          rise, chg;
    logic [15:0] pre;
    if (rst) begin
      m_state = 16'h0001; m_cnt = 16'h0000; m_prev_calib = 1'b0;
      m_prev_in = buf_inputs; m_rnd = 16'h0000; m_valid = 1'b0;
      m_mode = 0; m_age = 0;
    end else begin
      rise = calib_done && !m_prev_calib;
      chg  = (buf_inputs != m_prev_in);
      pre  = m_state;
      if (rise || chg) begin
        m_state = ((pre ^ m_cnt) == 16'h0) ? 16'h0001 : (pre ^ m_cnt);
        m_cnt   = 16'h0000;
      end else begin
        m_state = lfsr_next(pre);
        m_cnt   = m_cnt + 16'h1;
      end
      m_prev_calib = calib_done;
      m_prev_in    = buf_inputs;
      case (m_mode)
        0: if (rise) begin m_mode = 1; m_age = 0; end
        1: begin
          m_age++;
          if (m_age == GAP) begin m_rnd = pre; m_valid = 1'b1; m_mode = 2; end
        end
        default: if (rd_en) begin m_mode = 1; m_age = 0; m_valid = 1'b0; end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("state",     dut.state,   m_state);
    check("counter",   dut.counter, m_cnt);
    check("rnd",       rnd,         m_rnd);
    check("rnd_valid", rnd_valid,   m_valid);
  endtask

  typedef struct {
    bit          rst;
    bit          calib;
    logic [7:0]  inputs;
    bit          rd;
    logic [15:0] exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[8];

  logic [15:0] s_save, c_save, r_save, exp_mix;
  logic [15:0] words[$];
  int          acc_cyc[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 0, 8'h00, 0, 16'h0001, 16'd0};
    tbl[1] = '{0, 0, 8'h00, 0, 16'hB400, 16'd1};
    tbl[2] = '{0, 0, 8'h00, 1, 16'h5A00, 16'd2};
    tbl[3] = '{0, 0, 8'h00, 1, 16'h2D00, 16'd3};
    tbl[4] = '{0, 0, 8'h00, 0, 16'h1680, 16'd4};
    tbl[5] = '{0, 0, 8'h01, 0, 16'h1684, 16'd0};
    tbl[6] = '{0, 0, 8'h01, 0, 16'h0B42, 16'd1};
    tbl[7] = '{0, 0, 8'h01, 0, 16'h05A1, 16'd2};

    rst = 1'b1; calib_done = 1'b0; buf_inputs = 8'h00; rd_en = 1'b0;
    calib4 = 1'b0; in4 = 2'b00; rd4 = 1'b0;

    // Directed table: reset, free-running steps, ignored reads, one input reseed.
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; calib_done = tbl[i].calib;
      buf_inputs = tbl[i].inputs; rd_en = tbl[i].rd;
      step();
      check($sformatf("tbl%0d_state", i), dut.state,   tbl[i].exp_state);
      check($sformatf("tbl%0d_cnt", i),   dut.counter, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_rnd", i),   rnd,         16'h0000);
      check($sformatf("tbl%0d_valid", i), rnd_valid,   1'b0);
    end
    rd_en = 1'b0;

    // Zero-lockup guard and silent counter wrap on the 4-bit instance.
    rst = 1'b1; step(); rst = 1'b0;
    check("z4_reset_state", dut4.state, 4'h1);
    check("z4_reset_cnt",   dut4.counter, 4'h0);
    step(); check("z4_s1", dut4.state, 4'hC); check("z4_c1", dut4.counter, 4'h1);
    step(); check("z4_s2", dut4.state, 4'h6); check("z4_c2", dut4.counter, 4'h2);
    step(); check("z4_s3", dut4.state, 4'h3); check("z4_c3", dut4.counter, 4'h3);
    in4 = 2'b01; step();
    check("z4_guard_state", dut4.state,   4'h1);
    check("z4_guard_cnt",   dut4.counter, 4'h0);
    for (int i = 0; i < 16; i++) step();
    check("z4_cnt_wrap", dut4.counter, 4'h0);

    // Primary seed: calib rises while counter is 5.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10 && m_cnt != 16'd5; i++) step();
    check("seed_cnt_reached", m_cnt, 16'd5);
    s_save = m_state;
    calib_done = 1'b1; step();
    check("seed_mix_state", dut.state,   s_save ^ 16'd5);
    check("seed_mix_cnt",   dut.counter, 16'd0);
    for (int i = 0; i < 3; i++) step();
    check("fill_not_valid", rnd_valid, 1'b0);
    s_save = m_state;
    step();
    check("fill_valid",   rnd_valid, 1'b1);
    check("fill_capture", rnd,       s_save);

    // Handshake: rd_en held 10 cycles yields two words, 5 cycles apart.
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rnd_valid) begin words.push_back(rnd); acc_cyc.push_back(cyc); end
      step();
    end
    rd_en = 1'b0;
    check("hs_accept_count", words.size(), 2);
    if (words.size() == 2) begin
      check("hs_spacing", acc_cyc[1] - acc_cyc[0], 5);
      check("hs_words_differ", words[0] != words[1], 1'b1);
    end
    check("hs_valid_again", rnd_valid, 1'b1);

    // Reseeds while READY mix the state but leave the held word alone.
    r_save = rnd;
    for (int i = 0; i < 3; i++) begin
      s_save = m_state; c_save = m_cnt;
      exp_mix = ((s_save ^ c_save) == 16'h0) ? 16'h0001 : (s_save ^ c_save);
      buf_inputs = buf_inputs ^ 8'h10;
      step();
      check("rdy_toggle_state", dut.state, exp_mix);
      check("rdy_toggle_rnd",   rnd,       r_save);
      check("rdy_toggle_valid", rnd_valid, 1'b1);
    end
    calib_done = 1'b0; step();
    check("calib_fall_state", dut.state, lfsr_next(s_save ^ c_save));
    step();
    s_save = m_state; c_save = m_cnt;
    exp_mix = ((s_save ^ c_save) == 16'h0) ? 16'h0001 : (s_save ^ c_save);
    calib_done = 1'b1; buf_inputs = buf_inputs ^ 8'h81;
    step();
    check("dual_event_single_xor", dut.state, exp_mix);
    check("dual_event_rnd",        rnd,       r_save);

    // Reset in the middle of FILL; only a fresh calib rise restarts delivery.
    rd_en = 1'b1; step(); rd_en = 1'b0;
    step(); step();
    rst = 1'b1; calib_done = 1'b0; step(); rst = 1'b0;
    check("rst_fill_rnd",   rnd,       16'h0000);
    check("rst_fill_valid", rnd_valid, 1'b0);
    check("rst_fill_state", dut.state, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      rd_en = i[0];
      buf_inputs = (i == 4) ? ~buf_inputs : buf_inputs;
      step();
    end
    rd_en = 1'b0;
    check("wait_no_calib_valid", rnd_valid, 1'b0);
    calib_done = 1'b1;
    for (int i = 0; i < GAP + 1; i++) step();
    check("recal_valid", rnd_valid, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      rd_en = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) calib_done = ~calib_done;
      if ($urandom_range(0, 15) == 0) buf_inputs = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
